score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Producer of the `score` value consumed by the on-screen text renderer.
- Accumulates points from gameplay event pulses (pellet, power pellet, ghost) through a 2-stage add pipeline.
- Tracks the ghost combo multiplier, the session high score and a one-shot extra-life award.
- Sits between the game-logic/collision blocks and the text/HUD path.

Parameters:
- SCORE_WIDTH, 16, width of score and high_score outputs.
- SCORE_MAX, 9999, saturation ceiling; the HUD shows 4 BCD digits.
- PELLET_PTS, 10, points per pellet.
- POWER_PTS, 50, points per power pellet.
- GHOST_BASE_PTS, 200, points for the first ghost of a fright period.
- GHOST_COMBO_MAX, 4, ghosts per fright period that keep doubling; later ghosts score the capped value.
- EXTRA_LIFE_PTS, 5000, threshold for the extra-life award.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- MODE  input  game_mode_t  current game mode
- pellet_eaten  input  1  one-cycle pulse
- power_eaten  input  1  one-cycle pulse; starts a fright period
- ghost_eaten  input  1  one-cycle pulse
- fright_end  input  1  one-cycle pulse; fright period over
- score  output  SCORE_WIDTH  current game score, binary
- high_score  output  SCORE_WIDTH  best score since rst
- new_high  output  1  level; high at 1 while score has exceeded the high score held at game start
- extra_life  output  1  one-cycle pulse

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: score=0, high_score=0, new_high=0, extra_life=0.
  - Internal state: combo=0, life_awarded=0, stage-1 register=0, stage-1 valid=0.
  - rst overrides all other inputs in the same cycle.
- Active modes: any MODE other than GAME_MODE_LOADING, GAME_MODE_READY or GAME_MODE_FAIL.
  - Event pulses are sampled only in active modes and ignored otherwise.
- Game start: MODE enters GAME_MODE_READY from any other mode (edge detected on a registered copy of MODE).
  - Clears score, combo, life_awarded, new_high and the stage-1 register/valid.
  - high_score is retained.
  - Takes priority over a pending stage-1 commit in the same cycle.
- Stage 1 (event edge N): register delta = pellet*PELLET_PTS + power*POWER_PTS + ghost*ghost_pts, and set stage-1 valid.
- Stage 2 (edge N+1): score <= min(score + delta, SCORE_MAX).
  - Latency: event at edge N gives the updated score visible after edge N+1 and usable by a consumer at edge N+2.
  - Back-to-back events every cycle are supported with no stalls; no event is dropped.
- Width and saturation:
  - Compute the sum at SCORE_WIDTH+1 bits and compare against SCORE_MAX before truncating.
  - Score never exceeds SCORE_MAX and never wraps.
- Ghost combo:
  - ghost_pts = GHOST_BASE_PTS << min(combo, GHOST_COMBO_MAX-1).
  - Default values in order: 200, 400, 800, 1600, then 1600 for every further ghost.
  - combo increments on each ghost_eaten and saturates at GHOST_COMBO_MAX.
  - power_eaten or fright_end resets combo to 0.
  - If power_eaten and ghost_eaten arrive in the same cycle, the ghost is priced at combo 0 (200) and combo becomes 1.
  - fright_end together with ghost_eaten: the ghost is priced at the current combo, then combo becomes 0.
- Simultaneous events: all pulses in the same cycle are summed into one delta. Pellet+power+ghost at combo 0 = 260.
- Draining on FAIL:
  - A stage-1 delta captured in the last active cycle still commits in the FAIL cycle.
  - New events arriving during FAIL are ignored.
- High score:
  - high_score <= score, one cycle after score exceeds high_score.
  - On an equal score, no update is made.
  - new_high is set in that same cycle and holds until game start or rst.
- Extra life:
  - Pulses for exactly one cycle, the cycle after score first becomes >= EXTRA_LIFE_PTS in the current game.
  - Sets life_awarded, so it never re-fires in the same game, including while saturated at SCORE_MAX.

Test Plan:
1. Reset then active mode; 3 pellet pulses on consecutive cycles -> score 10, 20, 30 on edges N+1..N+3; high_score=30 one cycle after score reaches 30; new_high=1.
2. power_eaten, then 5 ghost_eaten pulses spaced 2 cycles apart -> score 50, 250, 650, 1450, 3050, 4650; then fright_end and one more ghost -> +200 = 4850.
3. Same-cycle pellet+power+ghost at combo 0 -> single increment of 260; combo=1 afterwards.
4. Preload score to 9990 by events, then ghost (200) -> score=9999 (saturated, no wrap). extra_life pulses exactly once, when score first reaches >=5000, and not again at 9999.
5. MODE -> GAME_MODE_READY with score 1200 and high 1500 -> score=0, high_score=1500, new_high=0. Events during READY/LOADING -> score stays 0.
6. Event in the last active cycle, MODE -> GAME_MODE_FAIL next cycle -> delta still commits. A pellet during FAIL -> no change. rst asserted mid-pipeline -> all outputs 0 next cycle, and no late commit.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: game score accumulator for the HUD text renderer.
//
// Purpose:
//   Sums gameplay event pulses (pellet, power pellet, ghost) into a delta in
//   stage 1 and adds that delta to the saturating score in stage 2. It also
//   tracks the ghost combo multiplier, the session high score and a one-shot
//   extra-life award.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   MODE          current game mode (game_mode_t)
//   pellet_eaten  one-cycle pulse
//   power_eaten   one-cycle pulse; starts a fright period
//   ghost_eaten   one-cycle pulse
//   fright_end    one-cycle pulse; the fright period is over
//   score         current game score, binary, saturates at SCORE_MAX
//   high_score    best score since rst
//   new_high      level; set while this game has beaten the starting high score
//   extra_life    one-cycle pulse when the score first reaches EXTRA_LIFE_PTS

package score_keeper_pkg;

    typedef enum logic [2:0] {
        GAME_MODE_LOADING = 3'd0,
        GAME_MODE_READY   = 3'd1,
        GAME_MODE_PLAY    = 3'd2,
        GAME_MODE_FRIGHT  = 3'd3,
        GAME_MODE_FAIL    = 3'd4,
        GAME_MODE_WIN     = 3'd5
    } game_mode_t;

endpackage

module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH     = 16,
    parameter int unsigned SCORE_MAX       = 9999,
    parameter int unsigned PELLET_PTS      = 10,
    parameter int unsigned POWER_PTS       = 50,
    parameter int unsigned GHOST_BASE_PTS  = 200,
    parameter int unsigned GHOST_COMBO_MAX = 4,
    parameter int unsigned EXTRA_LIFE_PTS  = 5000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  game_mode_t             MODE,
    input  logic                   pellet_eaten,
    input  logic                   power_eaten,
    input  logic                   ghost_eaten,
    input  logic                   fright_end,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [SCORE_WIDTH-1:0] high_score,
    output logic                   new_high,
    output logic                   extra_life
);

    localparam int unsigned COMBO_W = $clog2(GHOST_COMBO_MAX + 1);
    localparam int unsigned SUM_W   = SCORE_WIDTH + 1;

    game_mode_t             mode_q;
    logic [COMBO_W-1:0]     combo_q,      combo_d;
    logic [SCORE_WIDTH-1:0] delta_q,      delta_d;
    logic                   valid_q,      valid_d;
    logic [SCORE_WIDTH-1:0] score_q,      score_d;
    logic [SCORE_WIDTH-1:0] high_q,       high_d;
    logic                   new_high_q,   new_high_d;
    logic                   extra_life_q, extra_life_d;
    logic                   life_q,       life_d;

    logic                   active_c;
    logic                   game_start_c;
    logic                   pellet_c, power_c, ghost_c, fright_c;
    logic [COMBO_W-1:0]     price_lvl_c;
    logic [SCORE_WIDTH-1:0] ghost_pts_c;
    logic [SUM_W-1:0]       sum_c;

    // Mode qualification and game-start edge detection
    always_comb begin
        active_c     = !(MODE inside {GAME_MODE_LOADING, GAME_MODE_READY, GAME_MODE_FAIL});
        game_start_c = (MODE == GAME_MODE_READY) && (mode_q != GAME_MODE_READY);
        pellet_c     = active_c && pellet_eaten;
        power_c      = active_c && power_eaten;
        ghost_c      = active_c && ghost_eaten;
        fright_c     = active_c && fright_end;
    end

    // Ghost price: a power pellet in the same cycle restarts pricing at the base
    always_comb begin
        price_lvl_c = combo_q;
        if (power_c) begin
            price_lvl_c = '0;
        end else if (combo_q > COMBO_W'(GHOST_COMBO_MAX - 1)) begin
            price_lvl_c = COMBO_W'(GHOST_COMBO_MAX - 1);
        end
        ghost_pts_c = SCORE_WIDTH'(GHOST_BASE_PTS) << price_lvl_c;
    end

    // Next-state logic for both pipeline stages and the bookkeeping flags
    always_comb begin
        combo_d      = combo_q;
        delta_d      = (pellet_c ? SCORE_WIDTH'(PELLET_PTS) : '0)
                     + (power_c  ? SCORE_WIDTH'(POWER_PTS)  : '0)
                     + (ghost_c  ? ghost_pts_c              : '0);
        valid_d      = pellet_c || power_c || ghost_c;
        score_d      = score_q;
        high_d       = high_q;
        new_high_d   = new_high_q;
        extra_life_d = 1'b0;
        life_d       = life_q;

        // Combo: power/fright clear it; a ghost advances it after being priced
        if (power_c || fright_c) begin
            combo_d = '0;
        end
        if (ghost_c) begin
            if (power_c && !fright_c) begin
                combo_d = COMBO_W'(1);
            end else if (!power_c && !fright_c && (combo_q < COMBO_W'(GHOST_COMBO_MAX))) begin
                combo_d = combo_q + COMBO_W'(1);
            end
        end

        // Stage 2 commits regardless of mode so a delta captured before FAIL drains
        sum_c = SUM_W'(score_q) + SUM_W'(delta_q);
        if (valid_q) begin
            if (sum_c > SUM_W'(SCORE_MAX)) begin
                score_d = SCORE_WIDTH'(SCORE_MAX);
            end else begin
                score_d = SCORE_WIDTH'(sum_c);
            end
        end

        if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end

        if (!life_q && (score_q >= SCORE_WIDTH'(EXTRA_LIFE_PTS))) begin
            extra_life_d = 1'b1;
            life_d       = 1'b1;
        end

        // Game start wins over any pending commit; high score is kept
        if (game_start_c) begin
            score_d    = '0;
            combo_d    = '0;
            life_d     = 1'b0;
            new_high_d = 1'b0;
            delta_d    = '0;
            valid_d    = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= GAME_MODE_LOADING;
            combo_q      <= '0;
            delta_q      <= '0;
            valid_q      <= 1'b0;
            score_q      <= '0;
            high_q       <= '0;
            new_high_q   <= 1'b0;
            extra_life_q <= 1'b0;
            life_q       <= 1'b0;
        end else begin
            mode_q       <= MODE;
            combo_q      <= combo_d;
            delta_q      <= delta_d;
            valid_q      <= valid_d;
            score_q      <= score_d;
            high_q       <= high_d;
            new_high_q   <= new_high_d;
            extra_life_q <= extra_life_d;
            life_q       <= life_d;
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;
    assign extra_life = extra_life_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: pipeline latency, ghost combo pricing,
// saturation, extra-life one-shot, game start, FAIL draining and reset.
module tb_score_keeper;
    import score_keeper_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    game_mode_t  mode;
    logic        pellet_eaten, power_eaten, ghost_eaten, fright_end;
    logic [15:0] score, high_score;
    logic        new_high, extra_life;

    int checks   = 0;
    int errors   = 0;
    int life_cnt = 0;

    score_keeper dut (
        .clk          (clk),
        .rst          (rst),
        .MODE         (mode),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .ghost_eaten  (ghost_eaten),
        .fright_end   (fright_end),
        .score        (score),
        .high_score   (high_score),
        .new_high     (new_high),
        .extra_life   (extra_life)
    );

    always #5 clk = ~clk;

    // Count extra-life pulses on the falling edge, away from updates
    always @(negedge clk) begin
        if (extra_life === 1'b1) life_cnt++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_events();
        pellet_eaten = 1'b0;
        power_eaten  = 1'b0;
        ghost_eaten  = 1'b0;
        fright_end   = 1'b0;
    endtask

    int ghost_exp [5] = '{250, 650, 1450, 3050, 4650};

    initial begin
        rst  = 1'b1;
        mode = GAME_MODE_LOADING;
        clear_events();
        pellet_eaten = 1'b1;
        tick();
        pellet_eaten = 1'b0;
        rst = 1'b0;
        check("rst_score", 32'(score), 32'd0);
        check("rst_high", 32'(high_score), 32'd0);
        check("rst_new_high", 32'(new_high), 32'd0);
        check("rst_extra_life", 32'(extra_life), 32'd0);

        // Test 1: three consecutive pellets
        mode = GAME_MODE_READY;  tick();
        mode = GAME_MODE_PLAY;   tick();
        pellet_eaten = 1'b1;
        tick();
        check("t1_latency", 32'(score), 32'd0);
        tick();
        check("t1_score10", 32'(score), 32'd10);
        tick();
        pellet_eaten = 1'b0;
        check("t1_score20", 32'(score), 32'd20);
        check("t1_high10", 32'(high_score), 32'd10);
        tick();
        check("t1_score30", 32'(score), 32'd30);
        check("t1_high20", 32'(high_score), 32'd20);
        tick();
        check("t1_high30", 32'(high_score), 32'd30);
        check("t1_new_high", 32'(new_high), 32'd1);

        // Game start keeps the high score and clears the rest
        mode = GAME_MODE_READY;  tick();
        mode = GAME_MODE_PLAY;   tick();
        check("gs_score", 32'(score), 32'd0);
        check("gs_high", 32'(high_score), 32'd30);
        check("gs_new_high", 32'(new_high), 32'd0);

        // Test 2: power pellet then a ghost combo
        power_eaten = 1'b1;  tick();
        power_eaten = 1'b0;  tick();
        check("t2_power", 32'(score), 32'd50);
        for (int g = 0; g < 5; g++) begin
            ghost_eaten = 1'b1;  tick();
            ghost_eaten = 1'b0;  tick();
            check($sformatf("t2_ghost%0d", g), 32'(score), 32'(ghost_exp[g]));
        end
        fright_end = 1'b1;   tick();
        fright_end = 1'b0;   tick();
        ghost_eaten = 1'b1;  tick();
        ghost_eaten = 1'b0;  tick();
        check("t2_after_fright", 32'(score), 32'd4850);
        check("t2_new_high", 32'(new_high), 32'd1);
        check("t2_no_life_yet", 32'(life_cnt), 32'd0);

        // Test 3: pellet+power+ghost together = 260, crossing the extra-life threshold
        pellet_eaten = 1'b1;  power_eaten = 1'b1;  ghost_eaten = 1'b1;
        tick();
        clear_events();
        tick();
        check("t3_sum260", 32'(score), 32'd5110);
        check("t3_life_not_yet", 32'(extra_life), 32'd0);
        tick();
        check("t3_life_pulse", 32'(extra_life), 32'd1);
        tick();
        check("t3_life_one_cycle", 32'(extra_life), 32'd0);

        // Test 4: back-to-back ghosts from combo 1 (400,800,1600,1600), then 8x60
        ghost_eaten = 1'b1;
        tick(4);
        ghost_eaten  = 1'b0;
        pellet_eaten = 1'b1;
        power_eaten  = 1'b1;
        tick(8);
        clear_events();
        tick();
        check("t4_preload", 32'(score), 32'd9990);
        ghost_eaten = 1'b1;  tick();
        ghost_eaten = 1'b0;  tick();
        check("t4_saturate", 32'(score), 32'd9999);
        pellet_eaten = 1'b1; tick();
        pellet_eaten = 1'b0; tick();
        check("t4_no_wrap", 32'(score), 32'd9999);
        tick();
        check("t4_high", 32'(high_score), 32'd9999);
        check("t4_life_once", 32'(life_cnt), 32'd1);

        // Test 5: game start, then events in READY / LOADING are ignored
        mode = GAME_MODE_READY;
        tick();
        check("t5_score", 32'(score), 32'd0);
        check("t5_high", 32'(high_score), 32'd9999);
        check("t5_new_high", 32'(new_high), 32'd0);
        pellet_eaten = 1'b1;  ghost_eaten = 1'b1;
        tick(2);
        mode = GAME_MODE_LOADING;
        tick(2);
        clear_events();
        tick(2);
        check("t5_idle_events", 32'(score), 32'd0);

        // Test 6: delta captured in the last active cycle drains during FAIL
        mode = GAME_MODE_PLAY;
        pellet_eaten = 1'b1;  tick();
        pellet_eaten = 1'b0;
        mode = GAME_MODE_FAIL; tick();
        check("t6_drain", 32'(score), 32'd10);
        pellet_eaten = 1'b1;  tick();
        pellet_eaten = 1'b0;  tick();
        check("t6_fail_ignored", 32'(score), 32'd10);

        // Reset mid-pipeline leaves no late commit
        mode = GAME_MODE_PLAY;
        power_eaten = 1'b1;   tick();
        power_eaten = 1'b0;
        rst = 1'b1;           tick();
        rst = 1'b0;
        check("t6_rst_score", 32'(score), 32'd0);
        check("t6_rst_high", 32'(high_score), 32'd0);
        check("t6_rst_new_high", 32'(new_high), 32'd0);
        tick(2);
        check("t6_no_late_commit", 32'(score), 32'd0);
        check("t6_life_total", 32'(life_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
